// File: rtl/scan_pkg.sv
// Shared types and constants for the RDOQ scan position sequencer and its output stage.
package scan_pkg;

    localparam int ADDR_W   = 10;
    localparam int CRD_W    = 5;
    localparam int MIN_LOG2 = 2;
    localparam int MAX_LOG2 = 5;

    typedef enum logic [1:0] {
        DIAG = 2'd0,
        HOR  = 2'd1,
        VER  = 2'd2
    } scan_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] scan_pos;
        logic [ADDR_W-1:0] scan_addr;
        logic [CRD_W-1:0]  x;
        logic [CRD_W-1:0]  y;
        logic              first;
        logic              last;
    } beat_t;

    function automatic logic log2_ok(input logic [2:0] v);
        return (int'(v) >= MIN_LOG2) && (int'(v) <= MAX_LOG2);
    endfunction

    // Highest scan position of a (1<<w) x (1<<h) block; a full-width shift yields all ones.
    function automatic logic [ADDR_W-1:0] max_pos(input logic [2:0] w, input logic [2:0] h);
        logic [3:0] sum;
        sum = {1'b0, w} + {1'b0, h};
        return ~({ADDR_W{1'b1}} << sum);
    endfunction

endpackage

// File: rtl/scan_out_reg.sv
// One-entry valid/ready output register: loads a beat when the slot is free, holds it while stalled,
// and drops it on flush.
module scan_out_reg
    import scan_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  flush,
    input  logic  ready,
    input  beat_t din,
    output logic  valid,
    output beat_t dout,
    output logic  slot_free
);

    logic  valid_q;
    logic  valid_d;
    beat_t data_q;
    beat_t data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid     = valid_q;
    assign dout      = data_q;
    assign slot_free = !valid_q || ready;

endmodule

// File: rtl/scan_position_sequencer.sv
// Walks scan positions from the last significant position down to 0, queries the scan ROM mux
// controller for each raster address and streams (pos, addr, x, y) beats to the RDOQ cost stage.
module scan_position_sequencer
    import scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        cfg_log2_w,
    input  logic [2:0]        cfg_log2_h,
    input  logic [1:0]        cfg_scan_type,
    input  logic [ADDR_W-1:0] cfg_last_pos,
    output logic [2:0]        log2BlockWidth,
    output logic [2:0]        log2BlockHeight,
    output logic [1:0]        scanType,
    output logic [ADDR_W-1:0] scanPosition,
    input  logic [ADDR_W-1:0] scanAddress,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_scan_pos,
    output logic [ADDR_W-1:0] out_scan_addr,
    output logic [CRD_W-1:0]  out_x,
    output logic [CRD_W-1:0]  out_y,
    output logic              out_first,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    seq_state_e        state_q, state_d;
    logic [2:0]        log2_w_q, log2_w_d;
    logic [2:0]        log2_h_q, log2_h_d;
    scan_type_e        type_q, type_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [ADDR_W-1:0] start_pos_q, start_pos_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] pos_limit;
    logic [ADDR_W-1:0] width_mask;
    logic              load;
    logic              flush;
    logic              slot_free;
    beat_t             beat_in;
    beat_t             beat_out;

    assign pos_limit  = max_pos(cfg_log2_w, cfg_log2_h);
    assign width_mask = ~({ADDR_W{1'b1}} << log2_w_q);

    // x/y come from the raster address for every block shape, rectangles included.
    always_comb begin
        beat_in.scan_pos  = pos_q;
        beat_in.scan_addr = scanAddress;
        beat_in.x         = CRD_W'(scanAddress & width_mask);
        beat_in.y         = CRD_W'(scanAddress >> log2_w_q);
        beat_in.first     = (pos_q == start_pos_q);
        beat_in.last      = (pos_q == '0);
    end

    always_comb begin
        state_d     = state_q;
        log2_w_d    = log2_w_q;
        log2_h_d    = log2_h_q;
        type_d      = type_q;
        pos_d       = pos_q;
        start_pos_d = start_pos_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        load        = 1'b0;
        flush       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (log2_ok(cfg_log2_w) && log2_ok(cfg_log2_h)) begin
                        log2_w_d = cfg_log2_w;
                        log2_h_d = cfg_log2_h;
                        type_d   = scan_type_e'(cfg_scan_type);
                        state_d  = RUN;
                        if (cfg_last_pos > pos_limit) begin
                            pos_d = pos_limit;
                            err_d = 1'b1;
                        end else begin
                            pos_d = cfg_last_pos;
                        end
                        start_pos_d = pos_d;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (slot_free) begin
                    load = 1'b1;
                    if (pos_q == '0) begin
                        state_d = DRAIN;
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (out_valid && out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            log2_w_q    <= '0;
            log2_h_q    <= '0;
            type_q      <= DIAG;
            pos_q       <= '0;
            start_pos_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            log2_w_q    <= log2_w_d;
            log2_h_q    <= log2_h_d;
            type_q      <= type_d;
            pos_q       <= pos_d;
            start_pos_q <= start_pos_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    scan_out_reg u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .flush     (flush),
        .ready     (out_ready),
        .din       (beat_in),
        .valid     (out_valid),
        .dout      (beat_out),
        .slot_free (slot_free)
    );

    assign log2BlockWidth  = log2_w_q;
    assign log2BlockHeight = log2_h_q;
    assign scanType        = type_q;
    assign scanPosition    = pos_q;
    assign out_scan_pos    = beat_out.scan_pos;
    assign out_scan_addr   = beat_out.scan_addr;
    assign out_x           = beat_out.x;
    assign out_y           = beat_out.y;
    assign out_first       = beat_out.first;
    assign out_last        = beat_out.last;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;

endmodule

// File: doc/scan_position_sequencer.md
Name: scan_position_sequencer

Overview:
- Sequential stage directly upstream of the scan ROM mux controller in the RDOQ scan pattern generator.
- On a start command it walks scan positions in reverse, from lastScanPos down to 0, which is the order RDOQ visits coefficients.
- Each cycle it drives scanPosition, block size and scanType to the mux controller and takes back the combinational scanAddress.
- It emits a valid/ready stream of (scanPos, scanAddress, x, y) beats to the RDOQ cost stage.

Parameters:
- ADDR_W, 10: width of scan position and scan address.
- CRD_W, 5: width of each x/y coordinate.
- MIN_LOG2, 2: smallest legal log2 block dimension.
- MAX_LOG2, 5: largest legal log2 block dimension.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- abort  in  1  cancel the current walk.
- cfg_log2_w  in  3  log2 block width.
- cfg_log2_h  in  3  log2 block height.
- cfg_scan_type  in  2  0 diag, 1 horizontal, 2 vertical.
- cfg_last_pos  in  ADDR_W  last significant scan position.
- log2BlockWidth  out  3  to the mux controller (latched config).
- log2BlockHeight  out  3  to the mux controller (latched config).
- scanType  out  2  to the mux controller (latched config).
- scanPosition  out  ADDR_W  current position counter, to the mux controller.
- scanAddress  in  ADDR_W  raster address returned by the mux controller, combinational in the same cycle.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_scan_pos  out  ADDR_W  scan position of the beat.
- out_scan_addr  out  ADDR_W  raster address of the beat.
- out_x  out  CRD_W  column of the beat.
- out_y  out  CRD_W  row of the beat.
- out_first  out  1  beat carries cfg_last_pos.
- out_last  out  1  beat carries position 0.
- busy  out  1  FSM is not IDLE.
- done  out  1  one-cycle pulse after the final beat is accepted.
- err  out  1  one-cycle pulse on a rejected start or a clamped cfg_last_pos.

Behaviour:
- Reset: every output register goes to 0, FSM goes to IDLE. Reset mid-walk discards all state; no done pulse follows.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on start when both log2 values are within [MIN_LOG2, MAX_LOG2].
  - Config is latched on that edge.
  - scanPosition loads min(cfg_last_pos, 2^(w+h) - 1).
  - If clamping occurred, err pulses in the same cycle that RUN is entered.
- Start with an out-of-range log2 value: stay in IDLE, err pulses for 1 cycle.
- start while busy is ignored.
- RUN, output slot free (out_valid == 0, or out_valid & out_ready):
  - Capture scanPosition, scanAddress, x = scanAddress & ((1<<w) - 1), y = scanAddress >> w, first and last flags into the output register.
  - Set out_valid.
  - If scanPosition == 0, go to DRAIN; otherwise decrement scanPosition.
- RUN, slot held (out_valid & !out_ready): all output fields and scanPosition hold stable.
- DRAIN: when out_valid & out_ready, clear out_valid, pulse done, go to IDLE.
- Latency: first beat is valid 2 cycles after start. Throughput is 1 beat/cycle while out_ready = 1. A walk ending at position L produces exactly L+1 beats.
- abort in RUN or DRAIN: next cycle FSM is IDLE, out_valid = 0, no done. abort has priority over start.
- Rectangular blocks rely on the controller's pass-through. x and y are still derived from the raster address and width.
- Square blocks take scanAddress as the ROM output.
- Downstream may drop out_ready at any cycle. The valid/data pair never changes while valid & !ready.
- cfg_last_pos = 0: a single beat with out_first = out_last = 1.

Decomposition:
- Shared package scan_pkg holds:
  - scan_type_e (DIAG = 0, HOR = 1, VER = 2).
  - seq_state_e.
  - ADDR_W, CRD_W, MIN_LOG2, MAX_LOG2.
- Sub-module scan_out_reg: one-entry valid/ready output register with load/hold and flush (abort).

Test Plan:
- 4x4, diag, last = 15, out_ready = 1, reference diag ROM model: 16 consecutive beats.
  - out_scan_pos runs 15..0.
  - First beat has addr 15, x = 3, y = 3, first = 1.
  - Final beat has addr 0, last = 1.
  - done pulses 1 cycle after the final accept.
- 8x8, horizontal, last = 100: err pulses and scanPosition starts at 63; 64 beats are produced.
- 16x16, last = 40, out_ready toggled randomly (50%): 41 beats in order with no duplicates or drops, and fields stable while stalled.
- 8x4 rectangle, vertical, last = 5: beats carry addr 5..0 (pass-through), and addr 5 gives x = 5, y = 0.
- last = 0, 32x32: exactly one beat with first = last = 1, then done.
- Error and interruption cases:
  - log2_w = 6: no busy, err = 1.
  - abort after 3 beats: out_valid = 0 next cycle, busy = 0, no done.
  - rst_n low mid-walk: all outputs 0.
